ls_rs_multi: RTL and testbench
==============================

Name: ls_rs_multi

Overview:
Parametrised load/store reservation station sitting between the dispatcher and the LS buffer. It holds DEPTH memory ops waiting on base (r1) and store-data (r2) operands, snoops NUM_CDB common data buses, and forms effective address = imm + base. It issues one ready op per cycle through a valid/ready handshake, either oldest-ready-first or strict program order.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
NUM_CDB, 2, number of CDB broadcast channels snooped
TAG_W, 4, ROB tag width; tag 0 = "no dependency / value present"
DATA_W, 32, data/address width
OP_W, 6, opcode width
IN_ORDER, 0, 0 = issue oldest ready entry; 1 = only the oldest valid entry may issue

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
rdy_i  in  1  global enable; 0 freezes all state and outputs
clr_i  in  1  synchronous flush (misprediction)
disp_en_i  in  1  dispatch request
disp_op_i  in  OP_W  opcode
disp_imm_i  in  DATA_W  offset
disp_r1_data_i  in  DATA_W  base value (valid if r1 tag 0)
disp_r1_tag_i  in  TAG_W  base producer tag
disp_r2_data_i  in  DATA_W  store data (valid if r2 tag 0)
disp_r2_tag_i  in  TAG_W  store-data producer tag
disp_id_i  in  TAG_W  ROB id of this op
full_o  out  1  no free entry
empty_o  out  1  no valid entry
count_o  out  log2(DEPTH)+1  valid entry count
cdb_en_i  in  NUM_CDB  per-channel broadcast valid
cdb_tag_i  in  NUM_CDB*TAG_W  per-channel tag, channel k at [k*TAG_W +: TAG_W]
cdb_data_i  in  NUM_CDB*DATA_W  per-channel result, same packing
out_valid_o  out  1  issue valid to LS buffer
out_ready_i  in  1  LS buffer accepts
out_op_o  out  OP_W  opcode
out_addr_o  out  DATA_W  effective address
out_data_o  out  DATA_W  store data
out_id_o  out  TAG_W  ROB id

Behaviour:
- Reset (rst=0 at edge) or clr_i=1 (with rdy_i=1 or rst=0): all entries invalid, out_valid_o=0, full_o=0, empty_o=1, count_o=0; other outputs hold (don't-care). Reset dominates rdy_i; clr_i dominates dispatch and CDB in the same cycle.
- rdy_i=0: no state change; CDB broadcasts in such cycles are not captured (producers guarantee none).
- Dispatch: allocated to lowest-index free entry; dispatch while full_o=1 is a protocol violation, ignored. Operand with tag 0 is ready; address field = imm+base (mod 2^DATA_W) if r1 ready else imm.
- Dispatch-cycle wakeup: if a dispatched nonzero tag matches any same-cycle CDB channel, the operand enters ready with that data.
- CDB wakeup: for each waiting operand, tag match on an enabled channel sets ready; r1 adds data to address, r2 replaces data. Tag 0 never matches. Multiple channels matching the same tag carry identical data; lowest channel wins.
- Age: each entry records dispatch order; "oldest" = earliest dispatched among valid entries.
- Issue: output register loads when (!out_valid_o || out_ready_i) and a candidate exists; IN_ORDER=0 candidate = oldest entry with both operands ready; IN_ORDER=1 candidate = oldest valid entry, only if ready. Loaded entry freed same edge. Else out_valid_o clears on accept, holds with stable payload while out_valid_o && !out_ready_i.
- Latency: dispatch with ready operands in cycle n -> out_valid_o in cycle n+2 (if output free). CDB wakeup in cycle n -> out_valid_o earliest n+2.
- Simultaneous dispatch and issue when full: freed slot not reusable until next cycle; full_o, empty_o, count_o are registered, reflect state after the edge; count counts stored entries only (not output register).

Test Plan:
- Reset then dispatch op=3, imm=0x10, r1 data 0x100 tag0, r2 tag0, id=5 with out_ready_i=1 -> cycle n+2 out_valid_o=1, addr=0x110, id=5; count returns 0.
- Dispatch r1 tag=7, imm=4; two cycles later CDB ch1 tag7 data 0x200 -> out_addr_o=0x204 two cycles after broadcast.
- Fill 8 entries with all operands waiting -> full_o=1, count_o=8; 9th dispatch ignored; wake entry 3 -> freed, full_o=0.
- IN_ORDER=1: older entry waits on tag 2, younger ready -> no issue until tag 2 broadcast, then older issues first, younger next accepted cycle.
- out_ready_i=0 for 5 cycles with ready entry -> out_valid_o held, payload stable; CDB updates to other entries still captured.
- Entries valid, out_valid_o=1, clr_i with dispatch same cycle -> next cycle empty_o=1, out_valid_o=0, count_o=0.

Source files
------------

// File: rtl/ls_rs_multi.sv
// Load/store reservation station: holds memory ops until base/store-data operands arrive over the CDBs, then issues them with address = imm + base.
// Latency: dispatch with ready operands -> out_valid_o two cycles later; CDB wakeup -> out_valid_o two cycles later at the earliest.
// Backpressure: out_valid_o/out_ready_i handshake; the payload holds while stalled; full_o is raised and further dispatch is ignored when no entry is free.
module ls_rs_multi #(
  parameter int DEPTH    = 8,
  parameter int NUM_CDB  = 2,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6,
  parameter int IN_ORDER = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy_i,
  input  logic                        clr_i,
  input  logic                        disp_en_i,
  input  logic [OP_W-1:0]             disp_op_i,
  input  logic [DATA_W-1:0]           disp_imm_i,
  input  logic [DATA_W-1:0]           disp_r1_data_i,
  input  logic [TAG_W-1:0]            disp_r1_tag_i,
  input  logic [DATA_W-1:0]           disp_r2_data_i,
  input  logic [TAG_W-1:0]            disp_r2_tag_i,
  input  logic [TAG_W-1:0]            disp_id_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o,
  input  logic [NUM_CDB-1:0]          cdb_en_i,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OP_W-1:0]             out_op_o,
  output logic [DATA_W-1:0]           out_addr_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [TAG_W-1:0]            out_id_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  // addr accumulates imm, then imm+base once r1 resolves; data is store data once r2 resolves.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] addr;
    logic [TAG_W-1:0]  r1_tag;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  r2_tag;
    logic [TAG_W-1:0]  id;
  } ent_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  ent_t              ent_q [DEPTH];
  ent_t              ent_d [DEPTH];
  // older_q[j][i] = 1 when entry j was dispatched before entry i (meaningful only when both are valid).
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [DATA_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_id_q, out_id_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DATA_W:0]   s1, s2;
  logic [DEPTH-1:0]  rdy_vec, elig;
  logic [IW-1:0]     sel, free_idx;
  logic              have_cand, have_free, load, older_hit;
  logic [CW-1:0]     cnt;

  // Returns {hit, data} for a tag; tag 0 never matches, and the lowest matching channel wins.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    if (tag != '0) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cdb_en_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == tag)) begin
          r = {1'b1, cdb_data_i[k*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  // Next state: wakeup, issue select, dispatch, flush, and registered occupancy flags.
  always_comb begin
    valid_d     = valid_q;
    ent_d       = ent_q;
    older_d     = older_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    s1          = '0;
    s2          = '0;
    rdy_vec     = '0;
    elig        = '0;
    sel         = '0;
    free_idx    = '0;
    have_cand   = 1'b0;
    have_free   = 1'b0;
    load        = 1'b0;
    older_hit   = 1'b0;
    cnt         = '0;

    // CDB wakeup of stored operands: r1 folds the base into the address, r2 supplies store data.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        s1 = snoop(ent_q[i].r1_tag);
        s2 = snoop(ent_q[i].r2_tag);
        if (s1[DATA_W]) begin
          ent_d[i].r1_tag = '0;
          ent_d[i].addr   = ent_q[i].addr + s1[DATA_W-1:0];
        end
        if (s2[DATA_W]) begin
          ent_d[i].r2_tag = '0;
          ent_d[i].data   = s2[DATA_W-1:0];
        end
      end
      rdy_vec[i] = valid_q[i] && (ent_q[i].r1_tag == '0) && (ent_q[i].r2_tag == '0);
    end

    // Pick the oldest eligible entry; in-order mode considers every valid entry and then requires it to be ready.
    elig = (IN_ORDER != 0) ? valid_q : rdy_vec;
    for (int i = 0; i < DEPTH; i++) begin
      older_hit = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && elig[j] && older_q[j][i]) older_hit = 1'b1;
      end
      if (elig[i] && !older_hit) begin
        sel       = IW'(i);
        have_cand = 1'b1;
      end
    end
    have_cand = have_cand && rdy_vec[sel];

    load = have_cand && (!out_valid_q || out_ready_i);
    if (load) begin
      out_valid_d  = 1'b1;
      out_op_d     = ent_q[sel].op;
      out_addr_d   = ent_q[sel].addr;
      out_data_d   = ent_q[sel].data;
      out_id_d     = ent_q[sel].id;
      valid_d[sel] = 1'b0;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // Free slot comes from the pre-edge valid set, so a slot freed by issue is not reused this cycle.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx  = IW'(i);
        have_free = 1'b1;
      end
    end

    if (disp_en_i && have_free) begin
      s1 = snoop(disp_r1_tag_i);
      s2 = snoop(disp_r2_tag_i);
      ent_d[free_idx].op = disp_op_i;
      ent_d[free_idx].id = disp_id_i;
      if (disp_r1_tag_i == '0) begin
        ent_d[free_idx].r1_tag = '0;
        ent_d[free_idx].addr   = disp_imm_i + disp_r1_data_i;
      end else if (s1[DATA_W]) begin
        ent_d[free_idx].r1_tag = '0;
        ent_d[free_idx].addr   = disp_imm_i + s1[DATA_W-1:0];
      end else begin
        ent_d[free_idx].r1_tag = disp_r1_tag_i;
        ent_d[free_idx].addr   = disp_imm_i;
      end
      if (disp_r2_tag_i == '0) begin
        ent_d[free_idx].r2_tag = '0;
        ent_d[free_idx].data   = disp_r2_data_i;
      end else if (s2[DATA_W]) begin
        ent_d[free_idx].r2_tag = '0;
        ent_d[free_idx].data   = s2[DATA_W-1:0];
      end else begin
        ent_d[free_idx].r2_tag = disp_r2_tag_i;
        ent_d[free_idx].data   = disp_r2_data_i;
      end
      valid_d[free_idx] = 1'b1;
      // The newcomer is younger than every other entry.
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (IW'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end

    if (clr_i) begin
      valid_d     = '0;
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(valid_d[i]);
    count_d = cnt;
    full_d  = (cnt == CW'(DEPTH));
    empty_d = (cnt == '0);
  end

  // State register: synchronous reset, otherwise frozen whenever rdy_i is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (rdy_i) begin
      valid_q     <= valid_d;
      ent_q       <= ent_d;
      older_q     <= older_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      count_q     <= count_d;
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign out_valid_o = out_valid_q;
  assign out_op_o    = out_op_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_ls_rs_multi.sv
// Bench for ls_rs_multi: one oldest-ready instance and one in-order instance share stimulus.
// Latency: expected issues are queued at dispatch and compared when each DUT hands off.
// Backpressure: out_ready_i is shared by both instances and is dropped in the stall and flush steps.
module tb_ls_rs_multi;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy_i, clr_i, disp_en_i, out_ready_i;
  logic [5:0]  disp_op_i;
  logic [31:0] disp_imm_i, disp_r1_data_i, disp_r2_data_i;
  logic [3:0]  disp_r1_tag_i, disp_r2_tag_i, disp_id_i;
  logic [1:0]  cdb_en_i;
  logic [7:0]  cdb_tag_i;
  logic [63:0] cdb_data_i;

  logic        full0, empty0, ov0, full1, empty1, ov1;
  logic [3:0]  count0, count1, id0, id1;
  logic [5:0]  op0, op1;
  logic [31:0] addr0, addr1, data0, data1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  bit   on1    = 1'b0;

  always #5 clk = ~clk;

  ls_rs_multi #(.IN_ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .rdy_i(rdy_i), .clr_i(clr_i),
    .disp_en_i(disp_en_i), .disp_op_i(disp_op_i), .disp_imm_i(disp_imm_i),
    .disp_r1_data_i(disp_r1_data_i), .disp_r1_tag_i(disp_r1_tag_i),
    .disp_r2_data_i(disp_r2_data_i), .disp_r2_tag_i(disp_r2_tag_i), .disp_id_i(disp_id_i),
    .full_o(full0), .empty_o(empty0), .count_o(count0),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .out_valid_o(ov0), .out_ready_i(out_ready_i), .out_op_o(op0),
    .out_addr_o(addr0), .out_data_o(data0), .out_id_o(id0)
  );

  ls_rs_multi #(.IN_ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .rdy_i(rdy_i), .clr_i(clr_i),
    .disp_en_i(disp_en_i), .disp_op_i(disp_op_i), .disp_imm_i(disp_imm_i),
    .disp_r1_data_i(disp_r1_data_i), .disp_r1_tag_i(disp_r1_tag_i),
    .disp_r2_data_i(disp_r2_data_i), .disp_r2_tag_i(disp_r2_tag_i), .disp_id_i(disp_id_i),
    .full_o(full1), .empty_o(empty1), .count_o(count1),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .out_valid_o(ov1), .out_ready_i(out_ready_i), .out_op_o(op1),
    .out_addr_o(addr1), .out_data_o(data1), .out_id_o(id1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int op, input logic [31:0] addr, input logic [31:0] data, input int id);
    exp_t e;
    e.op   = 6'(op);
    e.addr = addr;
    e.data = data;
    e.id   = 4'(id);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_set(input int ch, input logic [3:0] tag, input logic [31:0] d);
    cdb_en_i[ch]         = 1'b1;
    cdb_tag_i[ch*4 +: 4]   = tag;
    cdb_data_i[ch*32 +: 32] = d;
  endtask

  // Presents one dispatch for exactly one cycle.
  task automatic disp(input int op, input logic [31:0] imm, input logic [31:0] r1d, input int r1t,
                      input logic [31:0] r2d, input int r2t, input int id);
    disp_en_i      = 1'b1;
    disp_op_i      = 6'(op);
    disp_imm_i     = imm;
    disp_r1_data_i = r1d;
    disp_r1_tag_i  = 4'(r1t);
    disp_r2_data_i = r2d;
    disp_r2_tag_i  = 4'(r2t);
    disp_id_i      = 4'(id);
    cyc();
    disp_en_i = 1'b0;
  endtask

  // Scoreboard pop on every accepted issue of each instance.
  always @(negedge clk) begin
    if (rst && rdy_i && ov0 && out_ready_i) begin
      chk("sb0 has entry", 128'(q0.size() > 0), 128'(1));
      if (q0.size() > 0) chk("issue0 payload", 128'({op0, addr0, data0, id0}), 128'(q0.pop_front()));
    end
    if (on1 && rst && rdy_i && ov1 && out_ready_i) begin
      chk("sb1 has entry", 128'(q1.size() > 0), 128'(1));
      if (q1.size() > 0) chk("issue1 payload", 128'({op1, addr1, data1, id1}), 128'(q1.pop_front()));
    end
  end

  initial begin
    rst = 1'b0; rdy_i = 1'b1; clr_i = 1'b0; disp_en_i = 1'b0; out_ready_i = 1'b1;
    disp_op_i = '0; disp_imm_i = '0; disp_r1_data_i = '0; disp_r1_tag_i = '0;
    disp_r2_data_i = '0; disp_r2_tag_i = '0; disp_id_i = '0;
    cdb_en_i = '0; cdb_tag_i = '0; cdb_data_i = '0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst out_valid", 128'(ov0), 128'(0));
    chk("rst empty", 128'(empty0), 128'(1));
    chk("rst full", 128'(full0), 128'(0));
    chk("rst count", 128'(count0), 128'(0));
    chk("rst full1", 128'(full1), 128'(0));
    cyc();
    rst = 1'b1;

    // Ready-operand dispatch: address 0x10+0x100, visible two cycles later.
    q0.push_back(mk(3, 32'h10 + 32'h100, 32'hAA, 5));
    disp(3, 32'h10, 32'h100, 0, 32'hAA, 0, 5);
    @(negedge clk);
    chk("disp n+1 count", 128'(count0), 128'(1));
    chk("disp n+1 valid", 128'(ov0), 128'(0));
    cyc();
    @(negedge clk);
    chk("disp n+2 valid", 128'(ov0), 128'(1));
    chk("disp n+2 addr", 128'(addr0), 128'(32'h110));
    chk("disp n+2 count", 128'(count0), 128'(0));
    cyc();
    @(negedge clk);
    chk("accept clears", 128'(ov0), 128'(0));

    // Base waits on tag 7; woken on channel 1 while channel 0 carries a different tag.
    cyc();
    q0.push_back(mk(1, 32'h4 + 32'h200, 32'h55, 6));
    disp(1, 32'h4, 32'hDEAD, 7, 32'h55, 0, 6);
    cyc();
    cdb_set(1, 4'd7, 32'h200);
    cdb_set(0, 4'd9, 32'h999);
    cyc();
    cdb_en_i = '0;
    @(negedge clk);
    chk("wake n+1 valid", 128'(ov0), 128'(0));
    cyc();
    @(negedge clk);
    chk("wake n+2 valid", 128'(ov0), 128'(1));
    chk("wake n+2 addr", 128'(addr0), 128'(32'h204));
    cyc();

    // Both operands woken by CDB in the dispatch cycle itself.
    q0.push_back(mk(2, 32'h20 + 32'h30, 32'h77, 9));
    cdb_set(0, 4'd4, 32'h77);
    cdb_set(1, 4'd5, 32'h30);
    disp(2, 32'h20, 32'h0, 5, 32'h0, 4, 9);
    cdb_en_i = '0;
    cyc();
    @(negedge clk);
    chk("dispwake n+2 valid", 128'(ov0), 128'(1));
    chk("dispwake data", 128'(data0), 128'(32'h77));
    cyc();

    // Fill all eight entries with waiting bases (tags 8..15), then overflow.
    for (int i = 0; i < 8; i++) disp(i, 32'(i * 16), 32'h0, 8 + i, 32'(32'h500 + i), 0, i);
    @(negedge clk);
    chk("fill full", 128'(full0), 128'(1));
    chk("fill count", 128'(count0), 128'(8));
    chk("fill empty", 128'(empty0), 128'(0));
    cyc();
    disp(6'h3F, 32'h1, 32'h1, 0, 32'h0, 0, 15);
    @(negedge clk);
    chk("overflow count", 128'(count0), 128'(8));
    cyc();
    q0.push_back(mk(3, 32'h30 + 32'h1000, 32'h503, 3));
    cdb_set(0, 4'd11, 32'h1000);
    cyc();
    cdb_en_i = '0;
    @(negedge clk);
    chk("woken still stored", 128'(count0), 128'(8));
    cyc();
    @(negedge clk);
    chk("freed full", 128'(full0), 128'(0));
    chk("freed count", 128'(count0), 128'(7));
    cyc();
    // Wake the rest in scrambled tag order; issue order must follow dispatch age.
    for (int i = 0; i < 8; i++)
      if (i != 3) q0.push_back(mk(i, 32'(i * 16 + 32'h2000 + i), 32'(32'h500 + i), i));
    cdb_set(0, 4'd8, 32'h2000);  cdb_set(1, 4'd9, 32'h2001);  cyc();
    cdb_set(0, 4'd12, 32'h2004); cdb_set(1, 4'd10, 32'h2002); cyc();
    cdb_set(0, 4'd13, 32'h2005); cdb_set(1, 4'd14, 32'h2006); cyc();
    cdb_en_i = '0;
    cdb_set(1, 4'd15, 32'h2007); cyc();
    cdb_en_i = '0;
    repeat (10) cyc();
    @(negedge clk);
    chk("drain empty", 128'(empty0), 128'(1));
    chk("drain count", 128'(count0), 128'(0));

    // Stall: output held for five cycles while a CDB wakes the stored entry.
    cyc();
    out_ready_i = 1'b0;
    q0.push_back(mk(4, 32'h40 + 32'h8, 32'h11, 1));
    disp(4, 32'h40, 32'h8, 0, 32'h11, 0, 1);
    q0.push_back(mk(5, 32'h50 + 32'h333, 32'h22, 2));
    disp(5, 32'h50, 32'h0, 3, 32'h22, 0, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold valid", 128'(ov0), 128'(1));
      chk("hold addr", 128'(addr0), 128'(32'h48));
      chk("hold id", 128'(id0), 128'(1));
      cyc();
      if (k == 1) cdb_set(0, 4'd3, 32'h333);
      else cdb_en_i = '0;
    end
    cdb_en_i = '0;
    out_ready_i = 1'b1;
    repeat (3) cyc();

    // In-order: the older entry blocks the younger ready one until tag 2 arrives.
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    q1.delete();
    on1 = 1'b1;
    q0.push_back(mk(8, 32'h200 + 32'h5, 32'h2, 11));
    q0.push_back(mk(7, 32'h100 + 32'h40, 32'h1, 10));
    q1.push_back(mk(7, 32'h100 + 32'h40, 32'h1, 10));
    q1.push_back(mk(8, 32'h200 + 32'h5, 32'h2, 11));
    disp(7, 32'h100, 32'h0, 2, 32'h1, 0, 10);
    disp(8, 32'h200, 32'h5, 0, 32'h2, 0, 11);
    repeat (3) cyc();
    @(negedge clk);
    chk("inorder blocked", 128'(ov1), 128'(0));
    chk("inorder count", 128'(count1), 128'(2));
    cyc();
    cdb_set(1, 4'd2, 32'h40);
    cyc();
    cdb_en_i = '0;
    @(negedge clk);
    chk("inorder n+1", 128'(ov1), 128'(0));
    cyc();
    @(negedge clk);
    chk("inorder older id", 128'(id1), 128'(10));
    cyc();
    @(negedge clk);
    chk("inorder younger id", 128'(id1), 128'(11));
    cyc();
    @(negedge clk);
    chk("inorder done", 128'(ov1), 128'(0));

    // Flush with entries stored, output stalled, and a dispatch in the same cycle.
    cyc();
    out_ready_i = 1'b0;
    q0.push_back(mk(9, 32'h11, 32'h2, 12));
    q1.push_back(mk(9, 32'h11, 32'h2, 12));
    disp(9, 32'h10, 32'h1, 0, 32'h2, 0, 12);
    disp(10, 32'h0, 32'h0, 6, 32'h0, 0, 13);
    @(negedge clk);
    chk("preflush valid", 128'(ov0), 128'(1));
    chk("preflush count", 128'(count0), 128'(1));
    cyc();
    clr_i = 1'b1;
    disp(11, 32'h0, 32'h0, 0, 32'h0, 0, 14);
    clr_i = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("flush empty", 128'(empty0), 128'(1));
    chk("flush valid", 128'(ov0), 128'(0));
    chk("flush count", 128'(count0), 128'(0));
    chk("flush valid1", 128'(ov1), 128'(0));
    chk("flush empty1", 128'(empty1), 128'(1));
    cyc();
    out_ready_i = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    chk("postflush empty", 128'(empty0), 128'(1));
    chk("sb0 drained", 128'(q0.size()), 128'(0));
    chk("sb1 drained", 128'(q1.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
